data_ram_ctrl: RTL and testbench

- Parametrised, multi-cycle data memory for the MIPS datapath; next generation of the single-cycle byte/halfword/word RAM.
- Adds a req/ack handshake with configurable wait states and sign/zero-extended sub-word loads.
- Detects misaligned and illegal-mode accesses.
- Sits between the MEM-stage controller and a word-organised storage array of 2**(ADDR_WIDTH-2) words.

---
 rtl/data_ram_ctrl.sv | 155 +++++++++++++++
 tb/tb_data_ram_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/data_ram_ctrl.sv
// rtl/data_ram_ctrl.sv - multi-cycle byte/halfword/word data RAM with req/ack handshake
module data_ram_ctrl #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [1:0]            mode,
    input  logic                  uns,
    input  logic [31:0]           wdata,
    output logic                  ready,
    output logic                  ack,
    output logic [31:0]           rdata,
    output logic                  err
);
    localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                state, state_next;
    logic [3:0]            cnt, cnt_next;
    logic                  ack_next, err_next;
    logic [31:0]           rdata_next;
    logic                  capture;

    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            mode_q;
    logic                  uns_q;
    logic [31:0]           wdata_q;

    // Contents survive clr; only power-up starts from all zeros.
    logic [31:0]           mem [DEPTH] = '{default: '0};

    logic [ADDR_WIDTH-3:0] word_idx;
    logic [1:0]            lane;
    logic [31:0]           mem_word;
    logic                  bad;
    logic                  done;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [31:0]           load_val;
    logic [3:0]            be;
    logic [31:0]           wr_word;
    logic                  wr_en;

    assign ready    = (state == IDLE);
    assign word_idx = addr_q[ADDR_WIDTH-1:2];
    assign lane     = addr_q[1:0];
    assign mem_word = mem[word_idx];
    assign done     = (state == ACCESS) && (cnt == 4'd0);
    assign bad      = (mode_q == 2'b11) ||
                      (mode_q == 2'b01 && addr_q[0]) ||
                      (mode_q == 2'b10 && addr_q[1:0] != 2'b00);
    assign wr_en    = done && we_q && !bad;

    // Lane selection and sign/zero extension of the loaded word.
    always_comb begin
        byte_sel = mem_word[{lane, 3'b000} +: 8];
        half_sel = addr_q[1] ? mem_word[31:16] : mem_word[15:0];
        case (mode_q)
            2'b00:   load_val = {{24{byte_sel[7] & ~uns_q}}, byte_sel};
            2'b01:   load_val = {{16{half_sel[15] & ~uns_q}}, half_sel};
            default: load_val = mem_word;
        endcase
    end

    // Byte enables and lane-replicated store data so each lane takes its own slice.
    always_comb begin
        case (mode_q)
            2'b00:   begin be = 4'b0001 << lane;                        wr_word = {4{wdata_q[7:0]}};  end
            2'b01:   begin be = addr_q[1] ? 4'b1100 : 4'b0011;          wr_word = {2{wdata_q[15:0]}}; end
            2'b10:   begin be = 4'b1111;                                wr_word = wdata_q;            end
            default: begin be = 4'b0000;                                wr_word = wdata_q;            end
        endcase
    end

    // Array write port; a rejected or aborted access never reaches here.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[word_idx][8*b +: 8] <= wr_word[8*b +: 8];
            end
        end
    end

    // Next-state, wait counter and completion outputs.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ack_next   = 1'b0;
        err_next   = 1'b0;
        rdata_next = rdata;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    capture    = 1'b1;
                    cnt_next   = WAIT_INIT;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt != 4'd0) begin
                    cnt_next = cnt - 4'd1;
                end else begin
                    state_next = IDLE;
                    ack_next   = 1'b1;
                    err_next   = bad;
                    if (bad)        rdata_next = 32'd0;
                    else if (!we_q) rdata_next = load_val;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Control state and registered response.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
            cnt   <= 4'd0;
            ack   <= 1'b0;
            err   <= 1'b0;
            rdata <= 32'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            ack   <= ack_next;
            err   <= err_next;
            rdata <= rdata_next;
        end
    end

    // Request capture; inputs are ignored for the rest of the access.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            mode_q  <= 2'b00;
            uns_q   <= 1'b0;
            wdata_q <= 32'd0;
        end else if (capture) begin
            we_q    <= we;
            addr_q  <= addr;
            mode_q  <= mode;
            uns_q   <= uns;
            wdata_q <= wdata;
        end
    end
endmodule

// File: tb/tb_data_ram_ctrl.sv
// tb/tb_data_ram_ctrl.sv - scoreboard bench for data_ram_ctrl at WAIT_CYCLES 0 and 3
module tb_data_ram_ctrl;
    logic        clk = 1'b0;
    logic        clr = 1'b1;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    logic        req0 = 0, we0 = 0, uns0 = 0, ready0, ack0, err0;
    logic [11:0] addr0 = 0;
    logic [1:0]  mode0 = 0;
    logic [31:0] wdata0 = 0, rdata0;
    logic        req3 = 0, we3 = 0, uns3 = 0, ready3, ack3, err3;
    logic [11:0] addr3 = 0;
    logic [1:0]  mode3 = 0;
    logic [31:0] wdata3 = 0, rdata3;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        bit          chk;
        int          cyc;
    } exp_t;
    exp_t q0[$];
    exp_t q3[$];

    data_ram_ctrl #(.ADDR_WIDTH(12), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .clr(clr), .req(req0), .we(we0), .addr(addr0), .mode(mode0),
        .uns(uns0), .wdata(wdata0), .ready(ready0), .ack(ack0), .rdata(rdata0), .err(err0));

    data_ram_ctrl #(.ADDR_WIDTH(12), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .clr(clr), .req(req3), .we(we3), .addr(addr3), .mode(mode3),
        .uns(uns3), .wdata(wdata3), .ready(ready3), .ack(ack3), .rdata(rdata3), .err(err3));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic mon(input int d, input logic [31:0] rd, input logic er);
        exp_t e;
        if ((d == 0 && q0.size() == 0) || (d == 3 && q3.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ack dut=%0d got=ack want=none cyc=%0d", d, cyc);
        end else begin
            e = (d == 0) ? q0.pop_front() : q3.pop_front();
            check($sformatf("err_d%0d_c%0d", d, e.cyc), {31'd0, er}, {31'd0, e.err});
            check($sformatf("ack_cycle_d%0d", d), cyc, e.cyc);
            if (e.chk) check($sformatf("rdata_d%0d_c%0d", d, e.cyc), rd, e.rdata);
        end
    endtask

    always @(negedge clk) begin
        if (ack0) mon(0, rdata0, err0);
        if (ack3) mon(3, rdata3, err3);
    end

    task automatic drive(input int d, input logic r, input logic w, input logic [11:0] a,
                         input logic [1:0] m, input logic u, input logic [31:0] wd);
        if (d == 0) begin req0 = r; we0 = w; addr0 = a; mode0 = m; uns0 = u; wdata0 = wd; end
        else        begin req3 = r; we3 = w; addr3 = a; mode3 = m; uns3 = u; wdata3 = wd; end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic op(input int d, input logic w, input logic [11:0] a, input logic [1:0] m,
                      input logic u, input logic [31:0] wd, input bit chk,
                      input logic [31:0] er, input logic ee, input bit expect_ack);
        int guard;
        exp_t e;
        guard = 0;
        while (((d == 0) ? ready0 : ready3) !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout dut=%0d got=0 want=1", d);
            return;
        end
        drive(d, 1'b1, w, a, m, u, wd);
        @(posedge clk);
        @(negedge clk);
        e.rdata = er;
        e.err   = ee;
        e.chk   = chk;
        e.cyc   = cyc + ((d == 0) ? 0 : 3) + 1;
        if (expect_ack) begin
            if (d == 0) q0.push_back(e);
            else        q3.push_back(e);
        end
        drive(d, 1'b0, ~w, ~a, ~m, ~u, ~wd);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((q0.size() != 0 || q3.size() != 0) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        repeat (8) @(negedge clk);
        check("q0_drained", q0.size(), 0);
        check("q3_drained", q3.size(), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_ready0", {31'd0, ready0}, 32'd1);
        check("rst_ack0",   {31'd0, ack0},   32'd0);
        check("rst_err0",   {31'd0, err0},   32'd0);
        check("rst_rdata0", rdata0,          32'd0);
        check("rst_ready3", {31'd0, ready3}, 32'd1);
        check("rst_rdata3", rdata3,          32'd0);
        clr = 1'b0;
        @(negedge clk);

        // WAIT_CYCLES=0: modes 0 byte, 1 half, 2 word, 3 illegal
        op(0, 1, 12'h010, 2, 0, 32'hDEADBEEF, 0, 32'h0,        0, 1);
        op(0, 0, 12'h010, 2, 0, 32'h0,        1, 32'hDEADBEEF, 0, 1);
        op(0, 1, 12'h012, 0, 0, 32'h0000007F, 0, 32'h0,        0, 1);
        op(0, 0, 12'h010, 2, 0, 32'h0,        1, 32'hDE7FBEEF, 0, 1);
        op(0, 0, 12'h013, 0, 0, 32'h0,        1, 32'hFFFFFFDE, 0, 1);
        op(0, 0, 12'h013, 0, 1, 32'h0,        1, 32'h000000DE, 0, 1);
        op(0, 0, 12'h010, 0, 0, 32'h0,        1, 32'hFFFFFFEF, 0, 1);
        op(0, 0, 12'h011, 0, 1, 32'h0,        1, 32'h000000BE, 0, 1);
        op(0, 0, 12'h010, 1, 0, 32'h0,        1, 32'hFFFFBEEF, 0, 1);
        op(0, 1, 12'h022, 1, 0, 32'h00008001, 0, 32'h0,        0, 1);
        op(0, 0, 12'h022, 1, 0, 32'h0,        1, 32'hFFFF8001, 0, 1);
        op(0, 0, 12'h022, 1, 1, 32'h0,        1, 32'h00008001, 0, 1);
        op(0, 0, 12'h020, 2, 0, 32'h0,        1, 32'h80010000, 0, 1);
        op(0, 0, 12'h011, 2, 0, 32'h0,        1, 32'h0,        1, 1);
        op(0, 1, 12'h021, 1, 0, 32'h0000FFFF, 1, 32'h0,        1, 1);
        op(0, 0, 12'h000, 3, 0, 32'h0,        1, 32'h0,        1, 1);
        op(0, 1, 12'h010, 3, 0, 32'h11111111, 1, 32'h0,        1, 1);
        op(0, 0, 12'h010, 2, 0, 32'h0,        1, 32'hDE7FBEEF, 0, 1);
        op(0, 0, 12'h020, 2, 0, 32'h0,        1, 32'h80010000, 0, 1);
        op(0, 1, 12'h020, 0, 0, 32'h000000AA, 0, 32'h0,        0, 1);
        op(0, 0, 12'h020, 2, 0, 32'h0,        1, 32'h800100AA, 0, 1);
        drain();

        // WAIT_CYCLES=3: a req held while busy must be dropped, not queued
        op(3, 1, 12'h080, 2, 0, 32'hCAFEF00D, 0, 32'h0, 0, 1);
        check("busy_ready3", {31'd0, ready3}, 32'd0);
        drive(3, 1'b1, 1'b1, 12'h0C0, 2'd2, 1'b0, 32'hFFFFFFFF);
        repeat (2) @(negedge clk);
        drive(3, 1'b0, 1'b0, 12'h0, 2'd0, 1'b0, 32'h0);
        op(3, 0, 12'h0C0, 2, 0, 32'h0, 1, 32'h00000000, 0, 1);
        op(3, 0, 12'h080, 2, 0, 32'h0, 1, 32'hCAFEF00D, 0, 1);
        op(3, 0, 12'h082, 1, 1, 32'h0, 1, 32'h0000CAFE, 0, 1);
        op(3, 0, 12'h081, 1, 0, 32'h0, 1, 32'h0,        1, 1);
        drain();

        // clr mid-access: store is dropped, no ack, ready right after clr
        op(3, 1, 12'h040, 2, 0, 32'h12345678, 0, 32'h0, 0, 0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("ready_after_clr", {31'd0, ready3}, 32'd1);
        repeat (6) @(negedge clk);
        op(3, 0, 12'h040, 2, 0, 32'h0, 1, 32'h00000000, 0, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end
endmodule
